uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial-to-parallel UART receiver; the DUT stage fed by the bench's UART driver and consumed by its monitor.
//  Samples the asynchronous rx line with 16x oversampling and recovers 8N1 or 8E1/8O1 frames.
//  Emits each byte on a valid/ready output with per-byte error flags.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        115200      line rate, bit/s
//  DATA_BITS   8           data bits per frame, 5..8, LSB first
//  PARITY_EN   0           1 = one parity bit follows the data
//  PARITY_ODD  0           1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          asynchronous reset, active-high
//  rx          in   1          serial line, idle high, asynchronous to clk
//  dout        out  DATA_BITS  received byte
//  dout_valid  out  1          dout, frame_err and parity_err are valid
//  dout_ready  in   1          consumer accepts the byte when dout_valid && dout_ready
//  frame_err   out  1          stop bit was sampled low; qualified by dout_valid
//  parity_err  out  1          parity mismatch; qualified by dout_valid
//  overrun     out  1          one-cycle pulse: a completed frame was dropped
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; synchroniser=2'b11; dout=0; dout_valid=0; frame_err=0; parity_err=0; overrun=0; busy=0.
//  - rx passes through a 2-FF synchroniser before any use. This adds 2 clk of latency.
//  - Tick generator: DIV = CLK_FREQ/(BAUD*16), integer-truncated. A one-cycle tick fires every DIV clk.
//    The tick counter runs freely; it is not restarted on each frame.
//  - FSM states: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE. A 4-bit sample counter counts ticks.
//    IDLE:   on a synchronised falling edge, clear the sample counter and go to START.
//    START:  at tick count 7 (mid-bit), if rx is still low, go to DATA. Otherwise it was a glitch: go to IDLE, no output.
//    DATA:   every 16 ticks, sample rx at mid-bit and shift it in LSB-first. After DATA_BITS samples, go to PARITY or STOP.
//    PARITY: sample at mid-bit. err = ^data ^ rx ^ PARITY_ODD.
//    STOP:   sample at mid-bit; frame_err_n = ~rx. Commit the frame and go to IDLE immediately.
//            Leaving at mid-stop lets a start bit that follows back-to-back be detected.
//  - Commit, if the output is free (!dout_valid or dout_ready this cycle):
//    load dout and the error flags, and set dout_valid=1 on the next clk.
//  - Commit while the output is occupied (dout_valid && !dout_ready): drop the new frame and pulse overrun for 1 clk.
//    dout and the flags keep the old byte.
//  - Handshake: while dout_valid=1 and dout_ready=0, dout and the flags are held stable.
//    dout_valid falls the clk after acceptance, unless a commit lands in that same cycle (back-to-back refill).
//  - A byte is committed and flagged even when frame_err=1.
//    If rx stays low (break), the FSM waits in IDLE for a rising edge before it re-arms the falling-edge detect.
//  - Reset asserted mid-frame aborts the frame immediately: no partial byte, no overrun.
//  - Latency: dout_valid rises about 2 + 16*(9.5+PARITY_EN)*DIV clk after the start-bit falling edge reaches rx.
// STRUCTURE
//  - uart_pkg (shared with the future uart_tx and the bench):
//    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
//    localparam OVERSAMPLE = 16;
//    function automatic int baud_div(int clk_hz, int baud);
//  - One sub-module, uart_baud_tick #(DIV): free-running counter, one-cycle tick output. It is reused by uart_tx.
//  - The synchroniser, FSM, shift register and output register stay in uart_rx.
// TESTING (defaults: DIV=27, bit period 432 clk)
//  1. Drive 8N1 0xA5, dout_ready=1 -> one dout_valid pulse, dout=8'hA5, frame_err=0, parity_err=0, overrun=0.
//  2. Drive 0x3C then 0xC3 back-to-back, dout_ready=0 until both frames have ended
//     -> dout=8'h3C held stable, overrun pulses once at the 0xC3 stop bit;
//     after ready, dout_valid drops and no 0xC3 appears.
//  3. PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err=1, dout=8'h07.
//     Repeat with parity bit 1 -> parity_err=0.
//  4. Send 0x55 with the stop bit forced low -> frame_err=1, dout=8'h55.
//     rx then held low for 20 bit periods -> no further dout_valid until rx returns high and a new frame is sent.
//  5. Pulse rx low for 100 clk (less than half a bit) -> FSM returns to IDLE, no dout_valid, busy is high for at most 8 ticks.
//  6. Assert rst during DATA bit 4 of 0xFF, release, then send 0x12
//     -> all outputs are 0 during reset, and the only byte received is 8'h12.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types, oversampling ratio and baud divider helper.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    localparam int OVERSAMPLE = 16;

    // Integer-truncated clocks per oversample tick.
    function automatic int baud_div(int clk_hz, int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Free-running divider emitting a one-cycle tick every DIV clocks.
// Revision: 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int c_cw = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_cw-1:0] r_cnt;
    logic            r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_cw'(DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + c_cw'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 16x oversampling UART receiver with valid/ready byte output.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_div = baud_div(CLK_FREQ, BAUD);

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    logic                 w_tick;
    logic                 w_fall;
    logic                 w_mid;
    logic                 w_out_free;
    uart_state_e          r_state;
    logic [3:0]           r_sample_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_dout_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    uart_baud_tick #(
        .DIV (c_div)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // A held-low line never produces a falling edge, so a break re-arms only after rx goes high.
    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_mid      = w_tick && (r_sample_cnt == 4'd15);
    assign w_out_free = !r_dout_valid || dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sample_cnt <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_sample_cnt <= 4'd0;
                        r_state      <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_sample_cnt == 4'd7) begin
                            r_sample_cnt <= 4'd0;
                            r_bit_cnt    <= 3'd0;
                            r_par_err    <= 1'b0;
                            r_state      <= r_rx_sync ? IDLE : DATA;
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                    if (w_mid) begin
                        r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                            r_state <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                    if (w_mid) begin
                        r_par_err <= ^r_shift ^ r_rx_sync ^ PARITY_ODD;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (w_mid) begin
                        r_state <= IDLE;
                        if (w_out_free) begin
                            r_dout       <= r_shift;
                            r_frame_err  <= ~r_rx_sync;
                            r_parity_err <= PARITY_EN ? r_par_err : 1'b0;
                            r_dout_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed self-checking bench for uart_rx (8N1 and 8E1 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_bit = 432;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx_a    = 1'b1;
    logic       rx_p    = 1'b1;
    logic       ready_a = 1'b0;
    logic       ready_p = 1'b0;
    logic [7:0] dout_a, dout_p;
    logic       valid_a, valid_p, fe_a, fe_p, pe_a, pe_p, ovr_a, ovr_p, busy_a, busy_p;

    int n_vec = 0;
    int n_err = 0;

    int         acc_a = 0, ovr_cnt_a = 0, hold_viol_a = 0, busy_cyc_a = 0;
    int         acc_p = 0;
    logic [7:0] last_a = 8'h00, last_p = 8'h00;
    logic       last_fe_a = 1'b0, last_pe_a = 1'b0, last_fe_p = 1'b0, last_pe_p = 1'b0;
    logic       pv_valid = 1'b0, pv_ready = 1'b0, pv_fe = 1'b0;
    logic [7:0] pv_dout = 8'h00;

    uart_rx u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_a),
        .dout       (dout_a),
        .dout_valid (valid_a),
        .dout_ready (ready_a),
        .frame_err  (fe_a),
        .parity_err (pe_a),
        .overrun    (ovr_a),
        .busy       (busy_a)
    );

    uart_rx #(
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) u_dut_p (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_p),
        .dout       (dout_p),
        .dout_valid (valid_p),
        .dout_ready (ready_p),
        .frame_err  (fe_p),
        .parity_err (pe_p),
        .overrun    (ovr_p),
        .busy       (busy_p)
    );

    always #10 clk = ~clk;

    // Consumer-side monitor: records accepted bytes, overrun pulses and hold violations.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a && ready_a) begin
                acc_a++;
                last_a    = dout_a;
                last_fe_a = fe_a;
                last_pe_a = pe_a;
            end
            if (ovr_a)  ovr_cnt_a++;
            if (busy_a) busy_cyc_a++;
            if (pv_valid && !pv_ready && (!valid_a || dout_a !== pv_dout || fe_a !== pv_fe))
                hold_viol_a++;
            if (valid_p && ready_p) begin
                acc_p++;
                last_p    = dout_p;
                last_fe_p = fe_p;
                last_pe_p = pe_p;
            end
        end
        pv_valid = valid_a;
        pv_ready = ready_a;
        pv_dout  = dout_a;
        pv_fe    = fe_a;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        @(posedge clk);
        #1;
        if (sel) rx_p = v;
        else     rx_a = v;
        repeat (c_bit - 1) @(posedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    task automatic test_reset;
        wait_clk(5);
        @(negedge clk);
        n_vec++; if (dout_a !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", dout_a); end
        n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_a); end
        n_vec++; if ({fe_a, pe_a, ovr_a} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {fe_a, pe_a, ovr_a}); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_a); end
        rst = 1'b0;
        wait_clk(c_bit);
    endtask

    task automatic test_basic;
        int a0, o0;
        a0 = acc_a; o0 = ovr_cnt_a;
        @(posedge clk); #1; ready_a = 1'b1;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_clk(c_bit);
        @(negedge clk);
        n_vec++; if (acc_a - a0 !== 1) begin n_err++; $display("FAIL basic_count got %0d want 1", acc_a - a0); end
        n_vec++; if (last_a !== 8'hA5) begin n_err++; $display("FAIL basic_dout got %h want a5", last_a); end
        n_vec++; if ({last_fe_a, last_pe_a} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b want 00", {last_fe_a, last_pe_a}); end
        n_vec++; if (ovr_cnt_a - o0 !== 0) begin n_err++; $display("FAIL basic_overrun got %0d want 0", ovr_cnt_a - o0); end
        n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got %b want 0", valid_a); end
    endtask

    task automatic test_back_to_back;
        int a0, o0, h0;
        @(posedge clk); #1; ready_a = 1'b0;
        a0 = acc_a; o0 = ovr_cnt_a; h0 = hold_viol_a;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_clk(100);
        @(negedge clk);
        n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL b2b_valid_held got %b want 1", valid_a); end
        n_vec++; if (dout_a !== 8'h3C) begin n_err++; $display("FAIL b2b_dout_held got %h want 3c", dout_a); end
        n_vec++; if (ovr_cnt_a - o0 !== 1) begin n_err++; $display("FAIL b2b_overrun got %0d want 1", ovr_cnt_a - o0); end
        n_vec++; if (hold_viol_a - h0 !== 0) begin n_err++; $display("FAIL b2b_stable got %0d want 0", hold_viol_a - h0); end
        n_vec++; if (acc_a - a0 !== 0) begin n_err++; $display("FAIL b2b_no_accept got %0d want 0", acc_a - a0); end
        @(posedge clk); #1; ready_a = 1'b1;
        wait_clk(2 * c_bit);
        @(negedge clk);
        n_vec++; if (acc_a - a0 !== 1) begin n_err++; $display("FAIL b2b_count got %0d want 1", acc_a - a0); end
        n_vec++; if (last_a !== 8'h3C) begin n_err++; $display("FAIL b2b_accepted got %h want 3c", last_a); end
        n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop got %b want 0", valid_a); end
    endtask

    task automatic test_parity;
        int p0;
        @(posedge clk); #1; ready_p = 1'b1;
        p0 = acc_p;
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_clk(c_bit);
        @(negedge clk);
        n_vec++; if (acc_p - p0 !== 1) begin n_err++; $display("FAIL par_bad_count got %0d want 1", acc_p - p0); end
        n_vec++; if (last_p !== 8'h07) begin n_err++; $display("FAIL par_bad_dout got %h want 07", last_p); end
        n_vec++; if ({last_pe_p, last_fe_p} !== 2'b10) begin n_err++; $display("FAIL par_bad_flags got %b want 10", {last_pe_p, last_fe_p}); end
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        wait_clk(c_bit);
        @(negedge clk);
        n_vec++; if (acc_p - p0 !== 2) begin n_err++; $display("FAIL par_good_count got %0d want 2", acc_p - p0); end
        n_vec++; if (last_p !== 8'h07) begin n_err++; $display("FAIL par_good_dout got %h want 07", last_p); end
        n_vec++; if ({last_pe_p, last_fe_p} !== 2'b00) begin n_err++; $display("FAIL par_good_flags got %b want 00", {last_pe_p, last_fe_p}); end
    endtask

    task automatic test_frame_err;
        int a0;
        a0 = acc_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_clk(20 * c_bit);
        @(negedge clk);
        n_vec++; if (acc_a - a0 !== 1) begin n_err++; $display("FAIL ferr_count got %0d want 1", acc_a - a0); end
        n_vec++; if (last_a !== 8'h55) begin n_err++; $display("FAIL ferr_dout got %h want 55", last_a); end
        n_vec++; if ({last_fe_a, last_pe_a} !== 2'b10) begin n_err++; $display("FAIL ferr_flags got %b want 10", {last_fe_a, last_pe_a}); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL ferr_break_idle got %b want 0", busy_a); end
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        wait_clk(c_bit);
        @(negedge clk);
        n_vec++; if (acc_a - a0 !== 2) begin n_err++; $display("FAIL ferr_rearm_count got %0d want 2", acc_a - a0); end
        n_vec++; if ({last_a, last_fe_a} !== {8'h5A, 1'b0}) begin n_err++; $display("FAIL ferr_rearm_byte got %h/%b want 5a/0", last_a, last_fe_a); end
    endtask

    task automatic test_glitch;
        int a0, b0, bd;
        a0 = acc_a; b0 = busy_cyc_a;
        @(posedge clk); #1; rx_a = 1'b0;
        wait_clk(100);
        #1; rx_a = 1'b1;
        wait_clk(2 * c_bit);
        @(negedge clk);
        bd = busy_cyc_a - b0;
        n_vec++; if (acc_a - a0 !== 0) begin n_err++; $display("FAIL glitch_no_byte got %0d want 0", acc_a - a0); end
        n_vec++; if (bd == 0 || bd > 8 * 27 + 2) begin n_err++; $display("FAIL glitch_busy_len got %0d want 1..218", bd); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL glitch_idle got %b want 0", busy_a); end
    endtask

    task automatic test_reset_mid_frame;
        int a0, o0;
        a0 = acc_a; o0 = ovr_cnt_a;
        fork
            send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                wait_clk(5 * c_bit + c_bit / 2);
                @(negedge clk);
                n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got %b want 1", busy_a); end
                @(posedge clk); #1; rst = 1'b1;
                wait_clk(3);
                @(negedge clk);
                n_vec++; if (dout_a !== 8'h00) begin n_err++; $display("FAIL rstmid_dout got %h want 00", dout_a); end
                n_vec++; if ({valid_a, fe_a, pe_a, ovr_a, busy_a} !== 5'b0) begin n_err++; $display("FAIL rstmid_outs got %b want 00000", {valid_a, fe_a, pe_a, ovr_a, busy_a}); end
                @(posedge clk); #1; rst = 1'b0;
            end
        join
        wait_clk(c_bit);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        wait_clk(c_bit);
        @(negedge clk);
        n_vec++; if (acc_a - a0 !== 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", acc_a - a0); end
        n_vec++; if (last_a !== 8'h12) begin n_err++; $display("FAIL rstmid_byte got %h want 12", last_a); end
        n_vec++; if (ovr_cnt_a - o0 !== 0) begin n_err++; $display("FAIL rstmid_overrun got %0d want 0", ovr_cnt_a - o0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
